vram_arbiter: RTL and testbench



---
 rtl/vram_arb_pkg.sv | 27 ++
 rtl/vram_arbiter_if.sv | 54 +++++
 rtl/vram_arb_rr.sv | 28 ++
 rtl/vram_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_arb_pkg.sv
// ============================================================================
// Module  : vram_arb_pkg
// Brief   : Shared types and constants for the two-port VRAM arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package vram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic port_t;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vram_arbiter_if.sv
// ============================================================================
// Module  : vram_arbiter_if
// Brief   : Requester and memory-side signals of the VRAM arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface vram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);

  logic              m0_sel_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic              m0_ack_o;
  logic [DATA_W-1:0] m0_data_o;

  logic              m1_sel_i;
  logic              m1_wr_i;
  logic [3:0]        m1_mask_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_data_i;
  logic              m1_ack_o;
  logic [DATA_W-1:0] m1_data_o;

  logic              vram_sel_o;
  logic              vram_wr_o;
  logic [3:0]        vram_mask_o;
  logic [ADDR_W-1:0] vram_addr_o;
  logic [DATA_W-1:0] vram_data_out_o;
  logic [DATA_W-1:0] vram_data_in_i;
  logic              vram_ack_i;

  // Arbiter side
  modport slave (
    input  m0_sel_i, m0_addr_i,
    input  m1_sel_i, m1_wr_i, m1_mask_i, m1_addr_i, m1_data_i,
    input  vram_data_in_i, vram_ack_i,
    output m0_ack_o, m0_data_o, m1_ack_o, m1_data_o,
    output vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_out_o
  );

  // Requesters plus memory controller side
  modport master (
    output m0_sel_i, m0_addr_i,
    output m1_sel_i, m1_wr_i, m1_mask_i, m1_addr_i, m1_data_i,
    output vram_data_in_i, vram_ack_i,
    input  m0_ack_o, m0_data_o, m1_ack_o, m1_data_o,
    input  vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_out_o
  );

endinterface

`default_nettype wire

// File: rtl/vram_arb_rr.sv
// ============================================================================
// Module  : vram_arb_rr
// Brief   : Combinational two-way round-robin pick.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vram_arb_rr
  import vram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  port_t      i_last_grant,
  output logic       o_gnt_valid,
  output port_t      o_gnt_idx
);

  always_comb begin
    o_gnt_valid = |i_req;
    if (&i_req) begin
      o_gnt_idx = ~i_last_grant;
    end else begin
      o_gnt_idx = i_req[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module  : vram_arbiter
// Brief   : Round-robin share of one VRAM port between display scanout (0)
//           and the rasterizer (1), with a no-ack watchdog.
//           Optional statistics counters: define VRAM_ARB_STATS_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_i,
  vram_arbiter_if.slave     bus,
  output logic              err_o
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_grant0_o,
  output logic [STAT_W-1:0] stat_grant1_o,
  output logic [STAT_W-1:0] stat_conflict_o
`endif
);

  state_t            r_state;
  state_t            w_state_nxt;
  port_t             r_owner;
  port_t             r_last_grant;
  logic              r_sel;
  logic              r_wr;
  logic [3:0]        r_mask;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_m0_ack;
  logic              r_m1_ack;
  logic [DATA_W-1:0] r_m0_data;
  logic [DATA_W-1:0] r_m1_data;
  logic              r_err;

  logic [1:0]        w_req;
  logic              w_gnt_valid;
  port_t             w_gnt_idx;
  logic              w_grant;
  logic              w_mem_ack;
  logic              w_timeout;

  assign w_req     = {bus.m1_sel_i, bus.m0_sel_i};
  assign w_grant   = (r_state == IDLE) && w_gnt_valid;
  assign w_mem_ack = bus.vram_ack_i && ((r_state == ISSUE) || (r_state == WAIT));

  vram_arb_rr u_rr (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_gnt_valid  (w_gnt_valid),
    .o_gnt_idx    (w_gnt_idx)
  );

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A watchdog abort also passes through DONE so the ack cycle never resamples sel
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt_valid) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = w_mem_ack ? DONE : WAIT;
      WAIT:    if (w_mem_ack || w_timeout) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_sel        <= 1'b0;
      r_wr         <= 1'b0;
      r_mask       <= 4'h0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_data    <= '0;
      r_m1_data    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;

      if (w_grant) begin
        r_owner      <= w_gnt_idx;
        r_last_grant <= w_gnt_idx;
        r_sel        <= 1'b1;
        if (w_gnt_idx == 1'b0) begin
          r_wr    <= 1'b0;
          r_mask  <= 4'hF;
          r_addr  <= bus.m0_addr_i;
          r_wdata <= '0;
        end else begin
          r_wr    <= bus.m1_wr_i;
          r_mask  <= bus.m1_mask_i;
          r_addr  <= bus.m1_addr_i;
          r_wdata <= bus.m1_data_i;
        end
      end

      if (w_mem_ack || w_timeout) begin
        r_sel <= 1'b0;
        if (r_owner == 1'b0) begin
          r_m0_ack  <= 1'b1;
          r_m0_data <= w_timeout ? '0 : bus.vram_data_in_i;
        end else begin
          r_m1_ack <= 1'b1;
          if (w_timeout) begin
            r_m1_data <= '0;
          end else if (!r_wr) begin
            r_m1_data <= bus.vram_data_in_i;
          end
        end
      end

      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [CNT_W-1:0] r_wait_cnt;

      always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
          r_wait_cnt <= '0;
        end else if (w_grant) begin
          r_wait_cnt <= '0;
        end else if ((r_state == WAIT) && !w_timeout) begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
      end

      // Fires on the TIMEOUT-th WAIT cycle; a real ack in that cycle wins
      assign w_timeout = (r_state == WAIT) && !bus.vram_ack_i &&
                         (r_wait_cnt == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_wdog
      assign w_timeout = 1'b0;
    end
  endgenerate

`ifdef VRAM_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat_g0;
  logic [STAT_W-1:0] r_stat_g1;
  logic [STAT_W-1:0] r_stat_conf;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_stat_g0   <= '0;
      r_stat_g1   <= '0;
      r_stat_conf <= '0;
    end else begin
      if (w_grant && (w_gnt_idx == 1'b0)) r_stat_g0 <= sat_inc(r_stat_g0);
      if (w_grant && (w_gnt_idx == 1'b1)) r_stat_g1 <= sat_inc(r_stat_g1);
      if ((r_state == IDLE) && (&w_req))  r_stat_conf <= sat_inc(r_stat_conf);
    end
  end

  assign stat_grant0_o   = r_stat_g0;
  assign stat_grant1_o   = r_stat_g1;
  assign stat_conflict_o = r_stat_conf;
`endif

  assign bus.vram_sel_o      = r_sel;
  assign bus.vram_wr_o       = r_wr;
  assign bus.vram_mask_o     = r_mask;
  assign bus.vram_addr_o     = r_addr;
  assign bus.vram_data_out_o = r_wdata;
  assign bus.m0_ack_o        = r_m0_ack;
  assign bus.m0_data_o       = r_m0_data;
  assign bus.m1_ack_o        = r_m1_ack;
  assign bus.m1_data_o       = r_m1_data;
  assign err_o               = r_err;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module  : tb_vram_arbiter
// Brief   : Scoreboard bench for vram_arbiter with a behavioural VRAM model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

  logic clk;
  logic reset_i;
  logic err_o;
  int   n_checks;
  int   n_pass;
  int   cyc;
  int   ack_at;
  int   sel_cnt;

  logic [15:0] mem [0:511];
  logic [15:0] sb0 [$];
  logic [15:0] sb1 [$];
  logic [15:0] last_m1_exp;

  typedef struct {
    logic        port;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [15:0] wdata;
    int          cyc;
  } gnt_t;
  gnt_t glog [$];

  vram_arbiter_if #(.ADDR_W(32), .DATA_W(16)) bus ();

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stat_grant0_o, stat_grant1_o, stat_conflict_o;
  logic [15:0] s0_base, s1_base, sc_base;
`endif

  vram_arbiter #(.ADDR_W(32), .DATA_W(16), .TIMEOUT(8)) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus),
    .err_o   (err_o)
`ifdef VRAM_ARB_STATS_EN
    ,
    .stat_grant0_o   (stat_grant0_o),
    .stat_grant1_o   (stat_grant1_o),
    .stat_conflict_o (stat_conflict_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // VRAM model: acks in the ack_at-th cycle of a request (0 = never)
  initial begin
    sel_cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.vram_sel_o) sel_cnt++;
      else sel_cnt = 0;
      if (sel_cnt == 1)
        glog.push_back('{bus.vram_addr_o[7], bus.vram_wr_o, bus.vram_mask_o,
                         bus.vram_addr_o, bus.vram_data_out_o, cyc});
      if (ack_at != 0 && sel_cnt == ack_at) begin
        bus.vram_ack_i     = 1'b1;
        bus.vram_data_in_i = mem[bus.vram_addr_o[8:0]];
        if (bus.vram_wr_o) begin
          if (bus.vram_mask_o[0]) mem[bus.vram_addr_o[8:0]][7:0]  = bus.vram_data_out_o[7:0];
          if (bus.vram_mask_o[1]) mem[bus.vram_addr_o[8:0]][15:8] = bus.vram_data_out_o[15:8];
        end
      end else begin
        bus.vram_ack_i     = 1'b0;
        bus.vram_data_in_i = 16'($urandom);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_i && bus.m0_ack_o) begin
        if (sb0.size() == 0) chk("m0_unexpected_ack", {31'd0, bus.m0_ack_o}, 32'd0);
        else chk("m0_data", {16'd0, bus.m0_data_o}, {16'd0, sb0.pop_front()});
      end
      if (!reset_i && bus.m1_ack_o) begin
        if (sb1.size() == 0) chk("m1_unexpected_ack", {31'd0, bus.m1_ack_o}, 32'd0);
        else chk("m1_data", {16'd0, bus.m1_data_o}, {16'd0, sb1.pop_front()});
      end
    end
  end

  task automatic drv(input logic port, input logic wr, input logic [3:0] mask,
                     input logic [31:0] base, input logic [15:0] wdata, input int n);
    logic        got;
    logic [31:0] a;
    logic [15:0] e;
    for (int i = 0; i < n; i++) begin
      a = base + i;
      if (!port) begin
        bus.m0_sel_i  = 1'b1;
        bus.m0_addr_i = a;
        sb0.push_back(mem[a[8:0]]);
      end else begin
        bus.m1_sel_i  = 1'b1;
        bus.m1_wr_i   = wr;
        bus.m1_mask_i = mask;
        bus.m1_addr_i = a;
        bus.m1_data_i = wdata;
        e = wr ? last_m1_exp : mem[a[8:0]];
        last_m1_exp = e;
        sb1.push_back(e);
      end
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clk);
        got = port ? bus.m1_ack_o : bus.m0_ack_o;
      end
      chk("ack_wait", {31'd0, got}, 32'd1);
    end
    if (!port) bus.m0_sel_i = 1'b0;
    else bus.m1_sel_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin : main
    int c0;
    int acks;
    n_checks = 0;
    n_pass = 0;
    ack_at = 0;
    last_m1_exp = 16'h0;
    for (int i = 0; i < 512; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h3C3C;
    mem[9'h040] = 16'h1234;
    bus.m0_sel_i = 0; bus.m0_addr_i = 0;
    bus.m1_sel_i = 0; bus.m1_wr_i = 0; bus.m1_mask_i = 0; bus.m1_addr_i = 0; bus.m1_data_i = 0;
    bus.vram_ack_i = 0; bus.vram_data_in_i = 0;
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sel", {31'd0, bus.vram_sel_o}, 32'd0);
    chk("rst_mask", {28'd0, bus.vram_mask_o}, 32'd0);
    chk("rst_acks", {30'd0, bus.m1_ack_o, bus.m0_ack_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
`ifdef VRAM_ARB_STATS_EN
    chk("rst_stat_conf", {16'd0, stat_conflict_o}, 32'd0);
`endif
    reset_i = 1'b0;
    repeat (2) @(negedge clk);

    // m1 write, ack in second WAIT cycle
    ack_at = 3;
    bus.m1_sel_i = 1; bus.m1_wr_i = 1; bus.m1_mask_i = 4'h3;
    bus.m1_addr_i = 32'h100; bus.m1_data_i = 16'hBEEF;
    sb1.push_back(last_m1_exp);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("t1_sel_c%0d", k), {31'd0, bus.vram_sel_o}, (k <= 3) ? 32'd1 : 32'd0);
      if (k == 1) begin
        chk("t1_wr", {31'd0, bus.vram_wr_o}, 32'd1);
        chk("t1_mask", {28'd0, bus.vram_mask_o}, 32'd3);
        chk("t1_addr", bus.vram_addr_o, 32'h100);
        chk("t1_wdata", {16'd0, bus.vram_data_out_o}, 32'hBEEF);
        bus.m1_addr_i = 32'h777; bus.m1_data_i = 16'h0; bus.m1_wr_i = 0;
      end
      if (k == 3) chk("t1_addr_hold", bus.vram_addr_o, 32'h100);
      if (k == 4) begin
        chk("t1_ack", {31'd0, bus.m1_ack_o}, 32'd1);
        chk("t1_m1_data_kept", {16'd0, bus.m1_data_o}, 32'd0);
        bus.m1_sel_i = 0;
      end
    end
    repeat (2) @(negedge clk);

    // m0 read
    ack_at = 2;
    glog.delete();
    drv(1'b0, 1'b0, 4'h0, 32'h40, 16'h0, 1);
    chk("t2_wr", {31'd0, glog[0].wr}, 32'd0);
    chk("t2_mask", {28'd0, glog[0].mask}, 32'hF);
    chk("t2_m0_data", {16'd0, bus.m0_data_o}, 32'h1234);
    @(negedge clk);

    drv(1'b1, 1'b0, 4'h0, 32'h100, 16'h0, 1);
    chk("wr_readback", {16'd0, bus.m1_data_o}, 32'hBEEF);
    @(negedge clk);

    // Conflict: both held for four accesses
    ack_at = 1;
    glog.delete();
`ifdef VRAM_ARB_STATS_EN
    s0_base = stat_grant0_o; s1_base = stat_grant1_o; sc_base = stat_conflict_o;
`endif
    fork
      drv(1'b0, 1'b0, 4'h0, 32'h40, 16'h0, 2);
      drv(1'b1, 1'b0, 4'h0, 32'h80, 16'h0, 2);
    join
    chk("t3_grants", glog.size(), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      chk($sformatf("t3_order%0d", i), {31'd0, glog[i].port}, 32'(i % 2));
`ifdef VRAM_ARB_STATS_EN
    @(negedge clk);
    chk("t3_stat_conf", {16'd0, 16'(stat_conflict_o - sc_base)}, 32'd3);
    chk("t3_stat_g0", {16'd0, 16'(stat_grant0_o - s0_base)}, 32'd2);
    chk("t3_stat_g1", {16'd0, 16'(stat_grant1_o - s1_base)}, 32'd2);
`endif
    repeat (2) @(negedge clk);

    // Watchdog: no ack for m1
    ack_at = 0;
    bus.m1_sel_i = 1; bus.m1_wr_i = 0; bus.m1_addr_i = 32'h90;
    last_m1_exp = 16'h0;
    sb1.push_back(16'h0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9) begin
        chk("t4_sel_c9", {31'd0, bus.vram_sel_o}, 32'd1);
        chk("t4_err_c9", {31'd0, err_o}, 32'd0);
        chk("t4_ack_c9", {31'd0, bus.m1_ack_o}, 32'd0);
      end
      if (k == 10) begin
        chk("t4_sel_c10", {31'd0, bus.vram_sel_o}, 32'd0);
        chk("t4_ack_c10", {31'd0, bus.m1_ack_o}, 32'd1);
        chk("t4_data", {16'd0, bus.m1_data_o}, 32'd0);
        chk("t4_err", {31'd0, err_o}, 32'd1);
        bus.m1_sel_i = 0;
      end
    end
    repeat (5) @(negedge clk);
    chk("t4_err_sticky", {31'd0, err_o}, 32'd1);

    // Reset while in WAIT
    bus.m0_sel_i = 1; bus.m0_addr_i = 32'h45;
    repeat (3) @(negedge clk);
    #2 reset_i = 1'b1;
    #1;
    chk("t5_sel", {31'd0, bus.vram_sel_o}, 32'd0);
    chk("t5_addr", bus.vram_addr_o, 32'd0);
    chk("t5_m0_data", {16'd0, bus.m0_data_o}, 32'd0);
    chk("t5_err", {31'd0, err_o}, 32'd0);
    bus.m0_sel_i = 0;
    @(negedge clk);
    reset_i = 1'b0;
    last_m1_exp = 16'h0;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      acks += int'(bus.m0_ack_o) + int'(bus.m1_ack_o);
    end
    chk("t5_no_ack", acks, 32'd0);

    // After reset port 0 wins the first conflict
    ack_at = 1;
    glog.delete();
    fork
      drv(1'b0, 1'b0, 4'h0, 32'h44, 16'h0, 1);
      drv(1'b1, 1'b0, 4'h0, 32'h84, 16'h0, 1);
    join
    chk("t5_grants", glog.size(), 32'd2);
    if (glog.size() == 2) begin
      chk("t5_first", {31'd0, glog[0].port}, 32'd0);
      chk("t5_second", {31'd0, glog[1].port}, 32'd1);
    end
    repeat (2) @(negedge clk);

    // m1 holds sel through its ack and re-requests
    glog.delete();
    drv(1'b1, 1'b0, 4'h0, 32'h88, 16'h0, 2);
    repeat (4) @(negedge clk);
    chk("t6_grants", glog.size(), 32'd2);
    if (glog.size() == 2) chk("t6_gap", glog[1].cyc - glog[0].cyc, 32'd3);
    chk("t6_sb_empty", sb0.size() + sb1.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
